fetch_queue_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-register PC of the single-cycle datapath. It generates sequential fetch addresses and issues reads on the imem side of datapath_cache_if. Fetched words go into a DEPTH-entry prefetch queue, which the decode/execute logic drains with a valid/ready handshake. It adds three things the single-cycle PC lacks: decoupled prefetch, redirect with queue flush for branches, jumps and JR, and a terminal halt state.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/fetch_queue_unit.sv | 114 +++++++++++
 tb/tb_fetch_queue_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU front-end types: fetch FSM states, queue entry layout, PC alignment.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Fetch unit runs until a halt instruction is accepted, then parks in HALTED.
  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // One prefetch queue entry; instr occupies the upper half when packed.
  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

  // Clears the two byte-offset bits so redirect targets land on a word.
  localparam word_t PC_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic word_t align_pc(word_t addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular buffer with push/pop/flush, occupancy count and combinational head read.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow; flush overrides both operations.
  always_comb begin
    do_push     = push && (count_reg != FULL_CNT) && !flush;
    do_pop      = pop && (count_reg != '0) && !flush;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by natural overflow.
      if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (do_push && !do_pop)      count_next = count_reg + CNT_W'(1);
      else if (do_pop && !do_push) count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage array; left unreset since only counted entries are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: sequential PC, imem read issue, prefetch queue,
// redirect with flush, and a terminal halt state.
module fetch_queue_unit
  import cpu_types_pkg::*;
#(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0,
  parameter int                DEPTH   = 4,
  parameter int                PC_INC  = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  output logic                       imemREN,
  output logic [WORD_W-1:0]          imemaddr,
  input  logic [WORD_W-1:0]          imemload,
  input  logic                       ihit,
  input  logic                       redirect,
  input  logic [WORD_W-1:0]          redirect_pc,
  input  logic                       halt_req,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic [WORD_W-1:0]          instr,
  output logic [WORD_W-1:0]          instr_pc,
  output logic [WORD_W-1:0]          instr_npc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halt
);

  localparam int                CNT_W      = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [WORD_W-1:0] INC        = WORD_W'(PC_INC);
  localparam logic [WORD_W-1:0] ALIGN_MASK = {{(WORD_W-2){1'b1}}, 2'b00};

  fetch_state_t        state_reg, state_next;
  logic [WORD_W-1:0]   fpc_reg, fpc_next;
  logic                halt_reg, halt_next;
  logic                push;
  logic                pop;
  logic                flush;
  logic [2*WORD_W-1:0] wr_entry;
  logic [2*WORD_W-1:0] head_entry;
  logic [CNT_W-1:0]    fifo_count;

  // Entry layout mirrors fetch_entry_t: instruction word above its address.
  assign wr_entry = {imemload, fpc_reg};

  sync_fifo #(
    .WIDTH (2*WORD_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (CLK),
    .srst  (RST),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wr_entry),
    .rdata (head_entry),
    .count (fifo_count)
  );

  // Next-state, fetch PC update and handshake decode; halt beats redirect,
  // redirect beats any hit or pop in the same cycle.
  always_comb begin
    state_next  = state_reg;
    fpc_next    = fpc_reg;
    halt_next   = halt_reg;
    flush       = 1'b0;
    imemREN     = (state_reg == FETCH) && (fifo_count != FULL_CNT) && !redirect;
    instr_valid = (state_reg == FETCH) && (fifo_count != '0);
    push        = imemREN && ihit && !halt_req;
    pop         = instr_valid && instr_ready && !redirect && !halt_req;
    case (state_reg)
      FETCH: begin
        if (halt_req) begin
          state_next = HALTED;
          halt_next  = 1'b1;
          flush      = 1'b1;
        end else if (redirect) begin
          flush    = 1'b1;
          fpc_next = redirect_pc & ALIGN_MASK;
        end else if (push) begin
          fpc_next = fpc_reg + INC;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // State, fetch PC and sticky halt registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= FETCH;
      fpc_reg   <= PC_INIT;
      halt_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      fpc_reg   <= fpc_next;
      halt_reg  <= halt_next;
    end
  end

  assign imemaddr  = fpc_reg;
  assign count     = fifo_count;
  assign halt      = halt_reg;
  assign instr     = head_entry[2*WORD_W-1:WORD_W];
  assign instr_pc  = head_entry[WORD_W-1:0];
  assign instr_npc = instr_pc + INC;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Two instances (PC_INIT 0 and FFFF_FFFC) share stimulus; a queue-based model
// built from the behavioural rules predicts every output each cycle.
module tb_fetch_queue_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ihit = 1'b0;
  logic        redirect = 1'b0;
  logic        halt_req = 1'b0;
  logic        instr_ready = 1'b0;
  logic [31:0] imemload = '0;
  logic [31:0] redirect_pc = '0;

  logic        ren  [2];
  logic [31:0] addr [2];
  logic        val  [2];
  logic [31:0] ins  [2];
  logic [31:0] ipc  [2];
  logic [31:0] inpc [2];
  logic [2:0]  cnt  [2];
  logic        hlt  [2];

  always #5 CLK = ~CLK;

  fetch_queue_unit #(.PC_INIT(32'h0000_0000)) dut0 (
    .CLK(CLK), .RST(RST), .imemREN(ren[0]), .imemaddr(addr[0]), .imemload(imemload),
    .ihit(ihit), .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .instr_valid(val[0]), .instr_ready(instr_ready), .instr(ins[0]), .instr_pc(ipc[0]),
    .instr_npc(inpc[0]), .count(cnt[0]), .halt(hlt[0])
  );

  fetch_queue_unit #(.PC_INIT(32'hFFFF_FFFC)) dut1 (
    .CLK(CLK), .RST(RST), .imemREN(ren[1]), .imemaddr(addr[1]), .imemload(imemload),
    .ihit(ihit), .redirect(redirect), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .instr_valid(val[1]), .instr_ready(instr_ready), .instr(ins[1]), .instr_pc(ipc[1]),
    .instr_npc(inpc[1]), .count(cnt[1]), .halt(hlt[1])
  );

  int errors = 0;
  int checks = 0;

  // Reference model: fetch PC, halted flag, and a plain queue of {pc, instr}.
  logic [31:0] init_pc [2];
  logic [31:0] m_fpc   [2];
  bit          m_halt  [2];
  logic [63:0] m_q     [2][$];
  bit          model_ok = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Compare all visible outputs against the model with the current inputs applied.
  task automatic model_check();
    bit          e_valid;
    bit          e_ren;
    logic [63:0] head;
    for (int k = 0; k < 2; k++) begin
      e_valid = (m_q[k].size() != 0) && !m_halt[k];
      e_ren   = !m_halt[k] && (m_q[k].size() < 4) && !redirect;
      chk($sformatf("d%0d_imemREN", k), 32'(ren[k]), 32'(e_ren));
      chk($sformatf("d%0d_imemaddr", k), addr[k], m_fpc[k]);
      chk($sformatf("d%0d_instr_valid", k), 32'(val[k]), 32'(e_valid));
      chk($sformatf("d%0d_count", k), 32'(cnt[k]), 32'(m_q[k].size()));
      chk($sformatf("d%0d_halt", k), 32'(hlt[k]), 32'(m_halt[k]));
      if (e_valid) begin
        head = m_q[k][0];
        chk($sformatf("d%0d_instr", k), ins[k], head[31:0]);
        chk($sformatf("d%0d_instr_pc", k), ipc[k], head[63:32]);
        chk($sformatf("d%0d_instr_npc", k), inpc[k], head[63:32] + 32'd4);
      end
    end
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_update();
    bit room;
    bit take;
    for (int k = 0; k < 2; k++) begin
      if (RST) begin
        m_fpc[k]  = init_pc[k];
        m_halt[k] = 0;
        m_q[k].delete();
      end else if (m_halt[k]) begin
        // parked until reset
      end else if (halt_req) begin
        m_halt[k] = 1;
        m_q[k].delete();
      end else if (redirect) begin
        m_q[k].delete();
        m_fpc[k] = {redirect_pc[31:2], 2'b00};
      end else begin
        room = m_q[k].size() < 4;
        take = (m_q[k].size() != 0) && instr_ready;
        if (take) void'(m_q[k].pop_front());
        if (room && ihit) begin
          m_q[k].push_back({m_fpc[k], imemload});
          m_fpc[k] = m_fpc[k] + 32'd4;
        end
      end
    end
    if (RST) model_ok = 1;
  endtask

  // One cycle: drive at negedge, check, clock, update model, then idle the inputs.
  task automatic step(input bit rst, input bit hi, input bit rdy, input bit rd,
                      input logic [31:0] rpc, input bit hr);
    RST = rst; ihit = hi; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    halt_req = hr; imemload = $urandom;
    #1;
    if (model_ok) model_check();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    RST = 0; ihit = 0; instr_ready = 0; redirect = 0; halt_req = 0;
    #1;
  endtask

  initial begin
    init_pc[0] = 32'h0000_0000;
    init_pc[1] = 32'hFFFF_FFFC;
    @(negedge CLK);

    // Reset state.
    step(1, 0, 0, 0, 0, 0);
    chk("rst_addr0", addr[0], 32'h0);
    chk("rst_addr1", addr[1], 32'hFFFF_FFFC);
    chk("rst_ren", 32'(ren[0]), 32'd1);
    chk("rst_valid", 32'(val[0]), 32'd0);
    chk("rst_count", 32'(cnt[0]), 32'd0);
    chk("rst_halt", 32'(hlt[0]), 32'd0);

    // Fill to capacity with the consumer stalled.
    repeat (4) step(0, 1, 0, 0, 0, 0);
    chk("full_count", 32'(cnt[0]), 32'd4);
    chk("full_ren", 32'(ren[0]), 32'd0);
    chk("full_addr", addr[0], 32'h10);
    chk("full_head_pc", ipc[0], 32'h0);
    step(0, 1, 1, 0, 0, 0);
    chk("full_pop_nopush_count", 32'(cnt[0]), 32'd3);
    chk("full_pop_nopush_addr", addr[0], 32'h10);

    // Streaming: one push and one pop per cycle after the first hit.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 1, 0, 0, 0);
      chk($sformatf("stream_pc%0d", i), ipc[0], 32'(4 * i));
      chk($sformatf("stream_npc%0d", i), inpc[0], 32'(4 * i + 4));
      chk($sformatf("stream_cnt%0d", i), 32'(cnt[0]), 32'd1);
    end

    // Redirect with a concurrent hit flushes and aligns the target.
    step(1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    chk("pre_redir_count", 32'(cnt[0]), 32'd3);
    step(0, 1, 1, 1, 32'h103, 0);
    chk("redir_count", 32'(cnt[0]), 32'd0);
    chk("redir_addr", addr[0], 32'h100);
    chk("redir_valid", 32'(val[0]), 32'd0);
    step(0, 1, 0, 0, 0, 0);
    chk("redir_first_pc", ipc[0], 32'h100);
    chk("redir_first_cnt", 32'(cnt[0]), 32'd1);

    // Halt wins over a simultaneous redirect and is terminal.
    step(0, 0, 0, 1, 32'h200, 1);
    chk("halt_set", 32'(hlt[0]), 32'd1);
    chk("halt_ren", 32'(ren[0]), 32'd0);
    chk("halt_valid", 32'(val[0]), 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(0, i[0], 1, !i[0], 32'h300, 0);
      chk($sformatf("halted_flag%0d", i), 32'(hlt[0]), 32'd1);
      chk($sformatf("halted_addr%0d", i), addr[0], 32'h104);
    end

    // Fetch PC wrap at the top of the address space, then reset mid-queue.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("wrap_pc", ipc[1], 32'hFFFF_FFFC);
    chk("wrap_npc", inpc[1], 32'h0);
    chk("wrap_addr", addr[1], 32'h0);
    chk("wrap_count", 32'(cnt[1]), 32'd1);
    step(1, 1, 0, 0, 0, 0);
    chk("midrst_count", 32'(cnt[1]), 32'd0);
    chk("midrst_addr", addr[1], 32'hFFFF_FFFC);

    // Randomised traffic, including resets, redirects and halts.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 3), ($urandom_range(99) < 70), ($urandom_range(99) < 60),
           ($urandom_range(99) < 6), $urandom, ($urandom_range(99) < 2));
    end
    step(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
